// File: rtl/bsg_dmc_refresh_sched_pkg.sv
// Shared types and constants for the DMC refresh scheduler slice.
package bsg_dmc_refresh_sched_pkg;

   // Init/refresh sequencer states: load init length, count it down, then run.
   typedef enum logic [1:0] {
      S_LOAD = 2'd0,
      S_INIT = 2'd1,
      S_RUN  = 2'd2
   } bsg_dmc_ref_state_e;

   // Maximum number of auto-refreshes that may be postponed (JEDEC limit).
   localparam int bsg_dmc_max_ref_postpone_gp = 8;

   // Width needed to hold a debt count in the range 0..max_pending.
   function automatic int ref_pending_width_f(input int max_pending);
      return $clog2(max_pending + 1);
   endfunction

endpackage

// File: rtl/bsg_dmc_refresh_sched_if.sv
// Refresh request channel between the refresh scheduler (master) and the
// DMC command scheduler (slave): valid/ready handshake plus debt status.
interface bsg_dmc_refresh_sched_if
   #(parameter int max_pending_p = 8);

   import bsg_dmc_refresh_sched_pkg::*;

   localparam int pending_width_lp = ref_pending_width_f(max_pending_p);

   logic                        ref_v;
   logic                        ref_ready;
   logic [pending_width_lp-1:0] ref_pending;
   logic                        ref_urgent;
   logic                        ref_overflow;

   modport master (
      output ref_v,
      output ref_pending,
      output ref_urgent,
      output ref_overflow,
      input  ref_ready
   );

   modport slave (
      input  ref_v,
      input  ref_pending,
      input  ref_urgent,
      input  ref_overflow,
      output ref_ready
   );

endinterface

// File: rtl/bsg_dmc_ref_debt_counter.sv
// Saturating up/down counter of outstanding refresh debt with a sticky flag
// that records a refresh tick lost because the debt was already saturated.
module bsg_dmc_ref_debt_counter
   import bsg_dmc_refresh_sched_pkg::*;
   #(parameter int max_pending_p = 8,
     parameter int width_p       = ref_pending_width_f(max_pending_p))
   (input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               clear_i,
    input  logic               inc_i,
    input  logic               dec_i,
    output logic [width_p-1:0] count_o,
    output logic               overflow_o);

   localparam logic [width_p-1:0] max_lp = width_p'(max_pending_p);
   localparam logic [width_p-1:0] one_lp = width_p'(1);

   logic [width_p-1:0] count_q, count_d;
   logic               overflow_q, overflow_d;

   // Next debt: simultaneous inc/dec cancel; a saturated inc only flags overflow.
   always_comb begin
      count_d    = count_q;
      overflow_d = overflow_q;
      if (clear_i) begin
         count_d    = '0;
         overflow_d = 1'b0;
      end else if (inc_i && !dec_i) begin
         if (count_q == max_lp) begin
            overflow_d = 1'b1;
         end else begin
            count_d = count_q + one_lp;
         end
      end else if (dec_i && !inc_i && (count_q != '0)) begin
         count_d = count_q - one_lp;
      end
   end

   // Debt and overflow state registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   assign count_o    = count_q;
   assign overflow_o = overflow_q;

endmodule

// File: rtl/bsg_dmc_refresh_sched.sv
// Power-up init wait and postponable auto-refresh request generator for the
// DMC, running in the dfi_clk_1x domain. Refresh ticks accumulate as debt that
// the command scheduler drains through a valid/ready handshake.
module bsg_dmc_refresh_sched
   import bsg_dmc_refresh_sched_pkg::*;
   #(parameter int trefi_width_p = 16,
     parameter int init_width_p  = 16,
     parameter int max_pending_p = bsg_dmc_max_ref_postpone_gp)
   (input  logic                     dfi_clk_1x_i,
    input  logic                     dfi_rst_n_i,
    input  logic                     sys_reset_i,
    input  logic [init_width_p-1:0]  init_cycles_i,
    input  logic [trefi_width_p-1:0] trefi_i,
    input  logic                     stall_i,
    output logic                     init_done_o,
    bsg_dmc_refresh_sched_if.master  ref_if);

   localparam int pending_width_lp = ref_pending_width_f(max_pending_p);
   localparam logic [pending_width_lp-1:0] urgent_thresh_lp =
      pending_width_lp'(max_pending_p - 1);
   localparam logic [trefi_width_p-1:0] ivl_one_lp = trefi_width_p'(1);
   localparam logic [init_width_p-1:0]  init_one_lp = init_width_p'(1);

   bsg_dmc_ref_state_e state_q, state_d;
   logic [init_width_p-1:0]  init_cnt_q, init_cnt_d;
   logic [trefi_width_p-1:0] ivl_cnt_q, ivl_cnt_d;
   logic                     init_done_q, init_done_d;

   logic                        in_run;
   logic                        tick;
   logic                        ref_v;
   logic                        xfer;
   logic [pending_width_lp-1:0] pending;
   logic                        overflow;

   assign in_run = (state_q == S_RUN);
   // A tick fires on the last cycle of each interval; a zero counter never ticks.
   assign tick   = in_run && (ivl_cnt_q == ivl_one_lp);
   // Valid depends only on registered state and stall, never on ready.
   assign ref_v  = in_run && (pending != '0) && !stall_i;
   assign xfer   = ref_v && ref_if.ref_ready;

   // Sequencer next state and init countdown; soft reset parks us in S_LOAD.
   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      if (sys_reset_i) begin
         state_d    = S_LOAD;
         init_cnt_d = '0;
      end else begin
         case (state_q)
            S_LOAD: begin
               init_cnt_d = init_cycles_i;
               state_d    = S_INIT;
            end
            S_INIT: begin
               if (init_cnt_q == '0) begin
                  state_d = S_RUN;
               end else begin
                  init_cnt_d = init_cnt_q - init_one_lp;
               end
            end
            S_RUN: begin
               state_d = S_RUN;
            end
            default: begin
               state_d = S_LOAD;
            end
         endcase
      end
      init_done_d = (state_d == S_RUN);
   end

   // Interval counter: reload on run entry, on each tick, and while parked at
   // zero so a newly written nonzero trefi takes effect on the next cycle.
   always_comb begin
      ivl_cnt_d = '0;
      if (!sys_reset_i && (state_d == S_RUN)) begin
         if (!in_run || tick || (ivl_cnt_q == '0)) begin
            ivl_cnt_d = trefi_i;
         end else begin
            ivl_cnt_d = ivl_cnt_q - ivl_one_lp;
         end
      end
   end

   // Sequencer, init counter, interval counter and init_done registers.
   always_ff @(posedge dfi_clk_1x_i or negedge dfi_rst_n_i) begin
      if (!dfi_rst_n_i) begin
         state_q     <= S_LOAD;
         init_cnt_q  <= '0;
         ivl_cnt_q   <= '0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         init_cnt_q  <= init_cnt_d;
         ivl_cnt_q   <= ivl_cnt_d;
         init_done_q <= init_done_d;
      end
   end

   bsg_dmc_ref_debt_counter #(
      .max_pending_p (max_pending_p),
      .width_p       (pending_width_lp)
   ) debt_cnt (
      .clk_i      (dfi_clk_1x_i),
      .rst_n_i    (dfi_rst_n_i),
      .clear_i    (sys_reset_i),
      .inc_i      (tick),
      .dec_i      (xfer),
      .count_o    (pending),
      .overflow_o (overflow)
   );

   assign init_done_o         = init_done_q;
   assign ref_if.ref_v        = ref_v;
   assign ref_if.ref_pending  = pending;
   assign ref_if.ref_urgent   = (pending >= urgent_thresh_lp);
   assign ref_if.ref_overflow = overflow;

endmodule

// File: tb/tb_bsg_dmc_refresh_sched.sv
// Directed self-checking bench for bsg_dmc_refresh_sched.
// Cycle 0 is the first cycle spent in S_LOAD after reset or a soft reset.
module tb_bsg_dmc_refresh_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sys_reset;
   logic [15:0] init_cycles;
   logic [15:0] trefi;
   logic        stall;
   logic        init_done;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   bsg_dmc_refresh_sched_if #(.max_pending_p(8)) ref_if ();

   bsg_dmc_refresh_sched #(
      .trefi_width_p (16),
      .init_width_p  (16),
      .max_pending_p (8)
   ) dut (
      .dfi_clk_1x_i  (clk),
      .dfi_rst_n_i   (rst_n),
      .sys_reset_i   (sys_reset),
      .init_cycles_i (init_cycles),
      .trefi_i       (trefi),
      .stall_i       (stall),
      .init_done_o   (init_done),
      .ref_if        (ref_if)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0d, required %0d", tag, obs, exp);
      end
   endtask

   // Advance n rising edges and settle on the following falling edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   // Pulse soft reset for one edge; returns at cycle 0 of the new sequence.
   task automatic restart(input logic [15:0] ic, input logic [15:0] tr);
      init_cycles = ic;
      trefi       = tr;
      sys_reset   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      sys_reset   = 1'b0;
   endtask

   initial begin
      int nv;
      int first;
      int pulses;
      int maxp;
      int xf;

      rst_n            = 1'b0;
      sys_reset        = 1'b0;
      init_cycles      = 16'd5;
      trefi            = 16'd0;
      stall            = 1'b0;
      ref_if.ref_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_init_done", init_done, 0);
      chk("rst_ref_v", ref_if.ref_v, 0);
      chk("rst_pending", ref_if.ref_pending, 0);
      chk("rst_urgent", ref_if.ref_urgent, 0);
      chk("rst_overflow", ref_if.ref_overflow, 0);

      // Test 1: init 5, refresh disabled.
      rst_n = 1'b1;
      step(6);
      chk("t1_init_done_c6", init_done, 0);
      step(1);
      chk("t1_init_done_c7", init_done, 1);
      nv = 0;
      for (int i = 0; i < 1000; i++) begin
         step(1);
         if (ref_if.ref_v) nv++;
      end
      chk("t1_no_ref_v", nv, 0);
      chk("t1_pending", ref_if.ref_pending, 0);

      // Test 2: init 0, trefi 10, always ready.
      ref_if.ref_ready = 1'b1;
      restart(16'd0, 16'd10);
      chk("t2_init_done_c0", init_done, 0);
      step(2);
      chk("t2_init_done_c2", init_done, 1);
      chk("t2_ref_v_c2", ref_if.ref_v, 0);
      first = 0; pulses = 0; maxp = 0;
      for (int k = 1; k <= 30; k++) begin
         step(1);
         if (ref_if.ref_v) begin
            if (first == 0) first = k;
            pulses++;
         end
         if (int'(ref_if.ref_pending) > maxp) maxp = int'(ref_if.ref_pending);
      end
      chk("t2_first_ref", first, 10);
      chk("t2_pulses", pulses, 3);
      chk("t2_max_pending", maxp, 1);

      // Test 3: trefi 4, never ready -> saturation and overflow, then drain.
      ref_if.ref_ready = 1'b0;
      restart(16'd0, 16'd4);
      step(29);
      chk("t3_pending_c29", ref_if.ref_pending, 6);
      chk("t3_urgent_c29", ref_if.ref_urgent, 0);
      step(1);
      chk("t3_pending_c30", ref_if.ref_pending, 7);
      chk("t3_urgent_c30", ref_if.ref_urgent, 1);
      chk("t3_overflow_c30", ref_if.ref_overflow, 0);
      step(4);
      chk("t3_pending_c34", ref_if.ref_pending, 8);
      step(3);
      chk("t3_overflow_c37", ref_if.ref_overflow, 0);
      chk("t3_pending_c37", ref_if.ref_pending, 8);
      step(1);
      chk("t3_overflow_c38", ref_if.ref_overflow, 1);
      chk("t3_pending_c38", ref_if.ref_pending, 8);
      chk("t3_ref_v_c38", ref_if.ref_v, 1);
      trefi = 16'd0;
      step(4);
      chk("t3_pending_c42", ref_if.ref_pending, 8);
      ref_if.ref_ready = 1'b1;
      xf = 0;
      for (int i = 0; i < 12; i++) begin
         if (ref_if.ref_v) xf++;
         step(1);
      end
      chk("t3_xfers", xf, 8);
      chk("t3_pending_drained", ref_if.ref_pending, 0);
      chk("t3_overflow_sticky", ref_if.ref_overflow, 1);
      ref_if.ref_ready = 1'b0;
      restart(16'd0, 16'd4);
      chk("t3_overflow_cleared", ref_if.ref_overflow, 0);

      // Test 4: stall masks valid while debt grows, then drains one per cycle.
      step(14);
      chk("t4_pending_c14", ref_if.ref_pending, 3);
      stall            = 1'b1;
      ref_if.ref_ready = 1'b1;
      #1;
      chk("t4_ref_v_stalled", ref_if.ref_v, 0);
      step(4);
      chk("t4_pending_c18", ref_if.ref_pending, 4);
      chk("t4_ref_v_c18", ref_if.ref_v, 0);
      trefi = 16'd0;
      step(4);
      chk("t4_pending_c22", ref_if.ref_pending, 5);
      stall = 1'b0;
      #1;
      chk("t4_ref_v_unstalled", ref_if.ref_v, 1);
      step(2);
      chk("t4_pending_c24", ref_if.ref_pending, 3);
      step(3);
      chk("t4_pending_c27", ref_if.ref_pending, 0);
      chk("t4_ref_v_c27", ref_if.ref_v, 0);

      // Test 5: tick and transfer in the same cycle.
      ref_if.ref_ready = 1'b0;
      restart(16'd0, 16'd4);
      step(13);
      chk("t5_pending_c13", ref_if.ref_pending, 2);
      ref_if.ref_ready = 1'b1;
      step(1);
      chk("t5_pending_tick_xfer", ref_if.ref_pending, 2);
      ref_if.ref_ready = 1'b0;
      step(27);
      chk("t5_pending_c41", ref_if.ref_pending, 8);
      ref_if.ref_ready = 1'b1;
      step(1);
      chk("t5_pending_sat_tick_xfer", ref_if.ref_pending, 8);
      chk("t5_no_overflow", ref_if.ref_overflow, 0);
      ref_if.ref_ready = 1'b0;

      // Test 6: soft reset mid-run, then init rerun with a new length.
      restart(16'd0, 16'd4);
      step(22);
      chk("t6_pending_c22", ref_if.ref_pending, 5);
      init_cycles = 16'd3;
      sys_reset   = 1'b1;
      step(1);
      chk("t6_sr_init_done", init_done, 0);
      chk("t6_sr_pending", ref_if.ref_pending, 0);
      chk("t6_sr_overflow", ref_if.ref_overflow, 0);
      chk("t6_sr_ref_v", ref_if.ref_v, 0);
      sys_reset = 1'b0;
      step(4);
      chk("t6_init_done_c4", init_done, 0);
      step(1);
      chk("t6_init_done_c5", init_done, 1);

      // Asynchronous reset while running with debt outstanding.
      restart(16'd0, 16'd4);
      step(22);
      chk("t6_pre_async_pending", ref_if.ref_pending, 5);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_async_pending", ref_if.ref_pending, 0);
      chk("t6_async_init_done", init_done, 0);
      chk("t6_async_ref_v", ref_if.ref_v, 0);
      chk("t6_async_urgent", ref_if.ref_urgent, 0);
      @(negedge clk);
      init_cycles = 16'd2;
      rst_n       = 1'b1;
      step(3);
      chk("t6_post_async_c3", init_done, 0);
      step(1);
      chk("t6_post_async_c4", init_done, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
